serial_rx_fsm: RTL and testbench

- Serial receiver that reassembles the frames produced by the team's FSM-based serial transmitter.
- Detects the start bit on the serial line and samples each bit at mid-period, using the same 3-bit baud divisor as the transmitter.
- Presents the 9-bit word with a one-cycle valid strobe and flags framing errors.
- Sits on the link side of the design, directly facing the transmitter's data_o line.

---
 rtl/serial_rx_fsm.sv | 156 +++++++++++++++
 tb/tb_serial_rx_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fsm.sv
`timescale 1ns/1ps
// serial_rx_fsm: receiver for frames made of a start bit (0), DATA_W data bits
// sent LSB first, and a stop bit (1). Each bit is sampled in the middle of its
// period. The period is T = SPB*(dvsr+1) clocks.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active low
//   data_i   serial line, idle high
//   dvsr_i   baud divisor, captured when a start edge is detected
//   data_o   last word received with a good stop bit
//   valid_o  one-cycle pulse when data_o is updated
//   err_o    one-cycle pulse when the stop bit is sampled low
//   busy_o   high while a frame is being received
module serial_rx_fsm #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned DVSR_W = 3,
    parameter int unsigned SPB    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    // The counter must reach T_max-1 for the largest divisor.
    localparam int unsigned T_MAX = SPB * (2 ** DVSR_W);
    localparam int unsigned CNT_W = $clog2(T_MAX);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [DVSR_W-1:0]   dvsr_q;
    logic [DATA_W-1:0]   shreg;

    logic                sync_meta;
    logic                sync_s;
    logic                prev_s;
    logic                fall;

    logic [CNT_W-1:0]    t_full_m1;
    logic [CNT_W-1:0]    t_half_m1;

    // Two-flop synchronizer plus a delayed copy used for edge detection.
    // The flops reset high so that leaving reset never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_meta <= 1'b1;
            sync_s    <= 1'b1;
            prev_s    <= 1'b1;
        end else begin
            sync_meta <= data_i;
            sync_s    <= sync_meta;
            prev_s    <= sync_s;
        end
    end

    assign fall = prev_s & ~sync_s;

    // Terminal counts for a full period and for half a period.
    // The divisor is taken from dvsr_q, which is held for the whole frame.
    always_comb begin
        t_full_m1 = CNT_W'(SPB * (32'(dvsr_q) + 32'd1) - 32'd1);
        t_half_m1 = CNT_W'((SPB / 2) * (32'(dvsr_q) + 32'd1) - 32'd1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= StIdle;
            cnt     <= '0;
            bit_idx <= '0;
            dvsr_q  <= '0;
            shreg   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            unique case (state)
                StIdle: begin
                    // A start needs a high-to-low transition. A line that stays
                    // low does not start a new frame.
                    if (fall) begin
                        state  <= StStart;
                        cnt    <= '0;
                        dvsr_q <= dvsr_i;
                        busy_o <= 1'b1;
                    end
                end

                StStart: begin
                    if (cnt == t_half_m1) begin
                        cnt <= '0;
                        if (!sync_s) begin
                            state   <= StData;
                            bit_idx <= '0;
                        end else begin
                            // The line went high again before mid-bit, so treat
                            // it as a glitch and report nothing.
                            state  <= StIdle;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                StData: begin
                    if (cnt == t_full_m1) begin
                        cnt   <= '0;
                        // Bits arrive LSB first, so shift them in from the top.
                        shreg <= {sync_s, shreg[DATA_W-1:1]};
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
                            state <= StStop;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                StStop: begin
                    if (cnt == t_full_m1) begin
                        cnt    <= '0;
                        state  <= StIdle;
                        busy_o <= 1'b0;
                        if (sync_s) begin
                            data_o  <= shreg;
                            valid_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= StIdle;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_fsm.sv
`timescale 1ns/1ps
// tb_serial_rx_fsm: drives directed serial frames into serial_rx_fsm.
// For each frame the bench records the cycle at which the frame starts.
// From that cycle and the bit period it builds a cycle-by-cycle timeline of
// the expected outputs. A compare process checks the DUT against this
// timeline on every falling clock edge. Literal latency and data checks fix
// the timeline to hand-computed values.
module tb_serial_rx_fsm;

    localparam int DATA_W  = 9;
    localparam int DVSR_W  = 3;
    localparam int SPB     = 4;
    localparam int MAX_CYC = 8192;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              data_i;
    logic [DVSR_W-1:0] dvsr_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              err_o;
    logic              busy_o;

    serial_rx_fsm #(
        .DATA_W (DATA_W),
        .DVSR_W (DVSR_W),
        .SPB    (SPB)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .dvsr_i  (dvsr_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // cyc holds the index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected outputs after each rising edge.
    bit              exp_valid [MAX_CYC];
    bit              exp_err   [MAX_CYC];
    bit              exp_busy  [MAX_CYC];
    logic [DATA_W-1:0] exp_data [MAX_CYC];

    int tests = 0;
    int fails = 0;
    int valid_count = 0;
    int err_count = 0;
    int busy_cycles = 0;
    int last_valid_cyc = -1;
    int last_err_cyc = -1;
    bit done = 1'b0;

    // e0 is the first edge that sees the start bit on data_i.
    // Two edges go to synchronization, half a period to the start check,
    // and one full period to each data bit and to the stop bit.
    function automatic void sched_frame(int e0, int t, logic [DATA_W-1:0] w, bit stop);
        int n;
        n = 2 + t / 2 + (DATA_W + 1) * t;
        for (int i = e0 + 2; i < e0 + n && i < MAX_CYC; i++) exp_busy[i] = 1'b1;
        if (e0 + n < MAX_CYC) begin
            if (stop) begin
                exp_valid[e0 + n] = 1'b1;
                for (int i = e0 + n; i < MAX_CYC; i++) exp_data[i] = w;
            end else begin
                exp_err[e0 + n] = 1'b1;
            end
        end
    endfunction

    // A one-clock low pulse enters START and is dropped at the mid-bit check.
    function automatic void sched_glitch(int e0, int t);
        for (int i = e0 + 2; i < e0 + t / 2 + 2 && i < MAX_CYC; i++) exp_busy[i] = 1'b1;
    endfunction

    function automatic void model_reset(int c);
        for (int i = c; i < MAX_CYC; i++) begin
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
            exp_busy[i]  = 1'b0;
            exp_data[i]  = '0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives the first nbits line bits of a frame, each held for t clocks.
    // When bit chg_bit is reached, dvsr_i is set to chg_val.
    task automatic send_frame(input logic [DATA_W-1:0] w, input int t, input bit stop,
                              input int nbits, input int chg_bit,
                              input logic [DVSR_W-1:0] chg_val, output int e0);
        e0 = cyc + 1;
        sched_frame(e0, t, w, stop);
        for (int b = 0; b < nbits; b++) begin
            if (b == chg_bit) dvsr_i = chg_val;
            if (b == 0) data_i = 1'b0;
            else if (b <= DATA_W) data_i = w[b-1];
            else data_i = stop;
            wait_cycles(t);
        end
    endtask

    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            valid_count    <= valid_count + 1;
            last_valid_cyc <= cyc;
        end
        if (err_o === 1'b1) begin
            err_count    <= err_count + 1;
            last_err_cyc <= cyc;
        end
        if (busy_o === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (!done && cyc > 0 && cyc < MAX_CYC) begin
                tests++;
                if (valid_o !== exp_valid[cyc] || err_o !== exp_err[cyc] ||
                    busy_o !== exp_busy[cyc] || data_o !== exp_data[cyc]) begin
                    fails++;
                    $display("FAIL cycle %0d: got v=%b e=%b b=%b d=0x%0h, expected v=%b e=%b b=%b d=0x%0h",
                             cyc, valid_o, err_o, busy_o, data_o,
                             exp_valid[cyc], exp_err[cyc], exp_busy[cyc], exp_data[cyc]);
                end
            end
        end
    end

    initial begin
        int e0;
        int e1;
        int vc;
        int ec;
        int bc;
        for (int i = 0; i < MAX_CYC; i++) exp_data[i] = '0;
        rst_i  = 1'b0;
        data_i = 1'b1;
        dvsr_i = '0;
        wait_cycles(3);
        check("reset data_o", 32'(data_o), 32'h0);
        check("reset valid_o", 32'(valid_o), 32'h0);
        check("reset err_o", 32'(err_o), 32'h0);
        check("reset busy_o", 32'(busy_o), 32'h0);
        rst_i = 1'b1;
        wait_cycles(5);

        // Frame with T=4: latency 2 + 2 + 40 = 44.
        dvsr_i = 3'd0;
        send_frame(9'h1A5, 4, 1'b1, 11, -1, 3'd0, e0);
        wait_cycles(4);
        check("t1 latency", 32'(last_valid_cyc - e0), 32'd44);
        check("t1 data", 32'(data_o), 32'h1A5);

        // Back-to-back frames with T=32: latency 2 + 16 + 320 = 338.
        dvsr_i = 3'd7;
        send_frame(9'h0FF, 32, 1'b1, 11, -1, 3'd0, e0);
        check("t2a latency", 32'(last_valid_cyc - e0), 32'd338);
        check("t2a data", 32'(data_o), 32'h0FF);
        send_frame(9'h100, 32, 1'b1, 11, -1, 3'd0, e1);
        wait_cycles(4);
        check("t2b latency", 32'(last_valid_cyc - e1), 32'd338);
        check("t2b data", 32'(data_o), 32'h100);

        // Frame with T=8 and a low stop bit. The line stays low afterwards.
        dvsr_i = 3'd1;
        vc = valid_count;
        send_frame(9'h055, 8, 1'b0, 11, -1, 3'd0, e0);
        wait_cycles(4);
        check("t3 err latency", 32'(last_err_cyc - e0), 32'd86);
        check("t3 data kept", 32'(data_o), 32'h100);
        check("t3 no valid", 32'(valid_count - vc), 32'd0);
        wait_cycles(200);
        check("t3 stuck low busy", 32'(busy_o), 32'd0);
        check("t3 stuck low err count", 32'(err_count), 32'd1);
        data_i = 1'b1;
        wait_cycles(10);
        send_frame(9'h0AA, 8, 1'b1, 11, -1, 3'd0, e0);
        wait_cycles(4);
        check("t3 recovery data", 32'(data_o), 32'h0AA);

        // One-clock low pulse with T=16.
        dvsr_i = 3'd3;
        bc = busy_cycles;
        vc = valid_count;
        ec = err_count;
        e0 = cyc + 1;
        sched_glitch(e0, 16);
        data_i = 1'b0;
        wait_cycles(1);
        data_i = 1'b1;
        wait_cycles(30);
        check("t4 busy cycles", 32'(busy_cycles - bc), 32'd8);
        check("t4 no valid", 32'(valid_count - vc), 32'd0);
        check("t4 no err", 32'(err_count - ec), 32'd0);

        // Reset in the middle of the data bits of a T=12 frame.
        dvsr_i = 3'd2;
        vc = valid_count;
        send_frame(9'h1FF, 12, 1'b1, 4, -1, 3'd0, e0);
        rst_i = 1'b0;
        model_reset(cyc);
        #1;
        check("t5 async clear data", 32'(data_o), 32'h0);
        check("t5 async clear busy", 32'(busy_o), 32'h0);
        data_i = 1'b1;
        wait_cycles(3);
        rst_i = 1'b1;
        wait_cycles(5);
        check("t5 no pulse", 32'(valid_count - vc), 32'd0);
        send_frame(9'h003, 12, 1'b1, 11, -1, 3'd0, e0);
        wait_cycles(4);
        check("t5 data after reset", 32'(data_o), 32'h003);

        // dvsr_i changes in the middle of a frame. The frame must still use T=12.
        dvsr_i = 3'd2;
        send_frame(9'h12C, 12, 1'b1, 11, 5, 3'd5, e0);
        wait_cycles(4);
        check("t6a latency", 32'(last_valid_cyc - e0), 32'd128);
        check("t6a data", 32'(data_o), 32'h12C);
        send_frame(9'h0F0, 24, 1'b1, 11, -1, 3'd0, e0);
        wait_cycles(4);
        check("t6b latency", 32'(last_valid_cyc - e0), 32'd254);
        check("t6b data", 32'(data_o), 32'h0F0);

        wait_cycles(10);
        check("total valid pulses", 32'(valid_count), 32'd7);
        check("total err pulses", 32'(err_count), 32'd1);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
